chimera_clu_gate_seq: RTL and testbench

CHIMERA_CLU_GATE_SEQ -- requirements
Module: chimera_clu_gate_seq

---
 rtl/chimera_pkg.sv | 23 ++
 rtl/chimera_clu_gate_fsm.sv | 116 +++++++++++
 rtl/chimera_clu_gate_seq.sv | 40 ++++
 tb/tb_chimera_clu_gate_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chimera_pkg.sv
// Shared types for the cluster clock-gate sequencer: FSM state encoding and
// the sizing helper for the per-cluster wait counter.
package chimera_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_ISO   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GATED = 3'd3,
        ST_WAKE  = 3'd4,
        ST_DEISO = 3'd5
    } gate_state_e;

    // Width able to hold the largest of the three cycle counts without wrapping.
    function automatic int cnt_width(input int drain, input int wake, input int tmo);
        int m;
        m = drain;
        if (wake > m) m = wake;
        if (tmo > m) m = tmo;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/chimera_clu_gate_fsm.sv
// Per-cluster clock-gate sequencer: isolate the AXI ports, drain, cut the
// clock, and reverse the order on wake. Moore outputs only.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | clock running, isolation released
//   ISO   | isolation requested, waiting for ack (abort / timeout possible)
//   DRAIN | ack seen, fixed DrainCycles hold before cutting the clock
//   GATED | clock cut, cluster isolated
//   WAKE  | clock restored, fixed WakeCycles hold while still isolated
//   DEISO | isolation released, waiting for ack to drop (timeout possible)
module chimera_clu_gate_fsm
    import chimera_pkg::*;
#(
    parameter int DrainCycles   = 8,
    parameter int WakeCycles    = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic gate_req_i,
    input  logic isolated_i,
    input  logic err_clr_i,
    output logic clk_en_o,
    output logic isolate_o,
    output logic gated_o,
    output logic busy_o,
    output logic err_o
);

    localparam int CntW = cnt_width(DrainCycles, WakeCycles, TimeoutCycles);
    localparam logic [CntW-1:0] DrainLast = CntW'(DrainCycles - 1);
    localparam logic [CntW-1:0] WakeLast  = CntW'(WakeCycles - 1);
    localparam logic [CntW-1:0] TmoLast   = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax    = {CntW{1'b1}};

    gate_state_e     r_state;
    gate_state_e     w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            r_err;
    logic            w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        w_tmo       = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (gate_req_i) w_state_nxt = ST_ISO;
            end
            ST_ISO: begin
                if (isolated_i) begin
                    w_state_nxt = ST_DRAIN;
                end else if (!gate_req_i) begin
                    w_state_nxt = ST_DEISO;
                end else if (r_cnt == TmoLast) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_DEISO;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DrainLast) w_state_nxt = ST_GATED;
            end
            ST_GATED: begin
                if (!gate_req_i) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (r_cnt == WakeLast) w_state_nxt = ST_DEISO;
            end
            ST_DEISO: begin
                if (!isolated_i) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == TmoLast) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Counter restarts on every state entry and saturates instead of wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CntMax) begin
            w_cnt_nxt = r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_tmo) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign clk_en_o  = (r_state != ST_GATED);
    assign isolate_o = (r_state == ST_ISO) || (r_state == ST_DRAIN) ||
                       (r_state == ST_GATED) || (r_state == ST_WAKE);
    assign gated_o   = (r_state == ST_GATED);
    assign busy_o    = (r_state == ST_ISO) || (r_state == ST_DRAIN) ||
                       (r_state == ST_WAKE) || (r_state == ST_DEISO);
    assign err_o     = r_err;

endmodule

// File: rtl/chimera_clu_gate_seq.sv
// Cluster clock-gate sequencer top: one independent gate FSM per cluster,
// sharing the error-clear pulse.
module chimera_clu_gate_seq #(
    parameter int NumClusters   = 5,
    parameter int DrainCycles   = 8,
    parameter int WakeCycles    = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] gate_req_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic                   err_clr_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] gated_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o
);

    for (genvar g = 0; g < NumClusters; g++) begin : g_clu
        chimera_clu_gate_fsm #(
            .DrainCycles  (DrainCycles),
            .WakeCycles   (WakeCycles),
            .TimeoutCycles(TimeoutCycles)
        ) u_fsm (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .gate_req_i(gate_req_i[g]),
            .isolated_i(isolated_i[g]),
            .err_clr_i (err_clr_i),
            .clk_en_o  (clk_en_o[g]),
            .isolate_o (isolate_o[g]),
            .gated_o   (gated_o[g]),
            .busy_o    (busy_o[g]),
            .err_o     (err_o[g])
        );
    end

endmodule

// File: tb/tb_chimera_clu_gate_seq.sv
// Scoreboard bench for chimera_clu_gate_seq: expected output bits are queued
// with their due cycle while stimulus is driven and compared on negedge.
module tb_chimera_clu_gate_seq;

    localparam int N = 5;
    localparam int D = 8;
    localparam int W = 4;
    localparam int T = 256;

    localparam int S_CLKEN = 0;
    localparam int S_ISO   = 1;
    localparam int S_GATED = 2;
    localparam int S_BUSY  = 3;
    localparam int S_ERR   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gate_req;
    logic [N-1:0] isolated;
    logic         err_clr;
    logic [N-1:0] clk_en;
    logic [N-1:0] isolate;
    logic [N-1:0] gated;
    logic [N-1:0] busy;
    logic [N-1:0] err;

    chimera_clu_gate_seq #(
        .NumClusters  (N),
        .DrainCycles  (D),
        .WakeCycles   (W),
        .TimeoutCycles(T)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .gate_req_i(gate_req),
        .isolated_i(isolated),
        .err_clr_i (err_clr),
        .clk_en_o  (clk_en),
        .isolate_o (isolate),
        .gated_o   (gated),
        .busy_o    (busy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        int           sig;
        logic [N-1:0] mask;
        logic [N-1:0] exp;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t sb_keep[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] pick(input int sig);
        case (sig)
            S_CLKEN: return clk_en;
            S_ISO:   return isolate;
            S_GATED: return gated;
            S_BUSY:  return busy;
            default: return err;
        endcase
    endfunction

    task automatic expect_at(input int at, input int sig, input logic [N-1:0] mask,
                             input logic [N-1:0] exp, input string tag);
        exp_t e;
        e.at   = at;
        e.sig  = sig;
        e.mask = mask;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic expect_idle(input int at, input string tag);
        expect_at(at, S_CLKEN, '1, '1, {tag, "_clken"});
        expect_at(at, S_ISO,   '1, '0, {tag, "_iso"});
        expect_at(at, S_GATED, '1, '0, {tag, "_gated"});
        expect_at(at, S_BUSY,  '1, '0, {tag, "_busy"});
        expect_at(at, S_ERR,   '1, '0, {tag, "_err"});
    endtask

    always @(negedge clk) begin
        sb_keep = {};
        foreach (sb[i]) begin
            if (sb[i].at == cyc)
                check(sb[i].tag, 32'(pick(sb[i].sig) & sb[i].mask), 32'(sb[i].exp & sb[i].mask));
            else
                sb_keep.push_back(sb[i]);
        end
        sb = sb_keep;
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [N-1:0] m;
        rst      = 1'b1;
        gate_req = '0;
        isolated = '0;
        err_clr  = 1'b0;

        for (int c = 1; c <= 4; c++) expect_idle(c, "reset");
        wait_until(3);
        rst = 1'b0;
        wait_until(6);

        // gate / ungate cycle on cluster 0, with a glitch on gate_req during DRAIN
        t0 = cyc;
        gate_req[0] = 1'b1;
        expect_at(t0,    S_ISO,   5'b00001, 5'b00000, "gc_iso_c0");
        expect_at(t0+1,  S_ISO,   5'b00001, 5'b00001, "gc_iso_c1");
        expect_at(t0+1,  S_BUSY,  5'b00001, 5'b00001, "gc_busy_c1");
        expect_at(t0+11, S_CLKEN, 5'b00001, 5'b00001, "gc_clken_c11");
        expect_at(t0+12, S_CLKEN, 5'b00001, 5'b00000, "gc_clken_c12");
        expect_at(t0+12, S_GATED, 5'b00001, 5'b00001, "gc_gated_c12");
        expect_at(t0+12, S_BUSY,  5'b00001, 5'b00000, "gc_busy_c12");
        expect_at(t0+12, S_CLKEN, 5'b11110, 5'b11110, "gc_others_clken");
        wait_until(t0+3);
        isolated[0] = 1'b1;
        wait_until(t0+6);
        gate_req[0] = 1'b0;
        wait_until(t0+7);
        gate_req[0] = 1'b1;
        wait_until(t0+20);
        gate_req[0] = 1'b0;
        expect_at(t0+20, S_CLKEN, 5'b00001, 5'b00000, "gc_clken_c20");
        expect_at(t0+21, S_CLKEN, 5'b00001, 5'b00001, "gc_clken_c21");
        expect_at(t0+21, S_GATED, 5'b00001, 5'b00000, "gc_gated_c21");
        expect_at(t0+21, S_ISO,   5'b00001, 5'b00001, "gc_iso_c21");
        expect_at(t0+21, S_BUSY,  5'b00001, 5'b00001, "gc_busy_c21");
        expect_at(t0+24, S_ISO,   5'b00001, 5'b00001, "gc_iso_c24");
        expect_at(t0+25, S_ISO,   5'b00001, 5'b00000, "gc_iso_c25");
        expect_at(t0+25, S_BUSY,  5'b00001, 5'b00001, "gc_busy_c25");
        expect_at(t0+26, S_ISO,   5'b00001, 5'b00000, "gc_iso_c26");
        expect_at(t0+27, S_BUSY,  5'b00001, 5'b00001, "gc_busy_c27");
        expect_at(t0+28, S_BUSY,  5'b00001, 5'b00000, "gc_busy_c28");
        expect_at(t0+28, S_CLKEN, 5'b00001, 5'b00001, "gc_clken_c28");
        wait_until(t0+27);
        isolated[0] = 1'b0;
        wait_until(t0+30);

        // abort on cluster 1: request withdrawn before any ack
        t0 = cyc;
        gate_req[1] = 1'b1;
        for (int k = 0; k <= 7; k++) expect_at(t0+k, S_CLKEN, 5'b00010, 5'b00010, "ab_clken");
        expect_at(t0+1, S_ISO,  5'b00010, 5'b00010, "ab_iso_c1");
        expect_at(t0+1, S_BUSY, 5'b00010, 5'b00010, "ab_busy_c1");
        expect_at(t0+5, S_ISO,  5'b00010, 5'b00010, "ab_iso_c5");
        expect_at(t0+6, S_ISO,  5'b00010, 5'b00000, "ab_deiso_iso");
        expect_at(t0+6, S_BUSY, 5'b00010, 5'b00010, "ab_deiso_busy");
        expect_at(t0+7, S_BUSY, 5'b00010, 5'b00000, "ab_run_busy");
        expect_at(t0+7, S_ERR,  5'b00010, 5'b00000, "ab_run_err");
        wait_until(t0+5);
        gate_req[1] = 1'b0;
        wait_until(t0+10);

        // ISO timeout on cluster 2, then clear
        t0 = cyc;
        gate_req[2] = 1'b1;
        for (int k = 0; k <= T+2; k++) expect_at(t0+k, S_CLKEN, 5'b00100, 5'b00100, "to_clken");
        expect_at(t0+1,   S_ISO,  5'b00100, 5'b00100, "to_iso_c1");
        expect_at(t0+T,   S_ISO,  5'b00100, 5'b00100, "to_iso_last");
        expect_at(t0+T,   S_ERR,  5'b00100, 5'b00000, "to_err_last");
        expect_at(t0+T+1, S_ERR,  5'b00100, 5'b00100, "to_err_set");
        expect_at(t0+T+1, S_ISO,  5'b00100, 5'b00000, "to_deiso_iso");
        expect_at(t0+T+1, S_BUSY, 5'b00100, 5'b00100, "to_deiso_busy");
        wait_until(t0+T+1);
        gate_req[2] = 1'b0;
        expect_at(t0+T+2, S_BUSY, 5'b00100, 5'b00000, "to_run_busy");
        expect_at(t0+T+2, S_ERR,  5'b00100, 5'b00100, "to_err_sticky");
        wait_until(t0+T+4);
        err_clr = 1'b1;
        expect_at(t0+T+4, S_ERR, 5'b00100, 5'b00100, "to_err_preclr");
        expect_at(t0+T+5, S_ERR, 5'b00100, 5'b00000, "to_err_clr");
        wait_until(t0+T+5);
        err_clr = 1'b0;
        wait_until(t0+T+8);

        // timeout and clear in the same cycle on cluster 3: set wins
        t0 = cyc;
        gate_req[3] = 1'b1;
        wait_until(t0+T);
        err_clr = 1'b1;
        expect_at(t0+T+1, S_ERR, 5'b01000, 5'b01000, "sc_err_set_wins");
        wait_until(t0+T+1);
        err_clr = 1'b0;
        gate_req[3] = 1'b0;
        expect_at(t0+T+2, S_ERR, 5'b01000, 5'b01000, "sc_err_sticky");
        wait_until(t0+T+3);
        err_clr = 1'b1;
        expect_at(t0+T+4, S_ERR, 5'b01000, 5'b00000, "sc_err_clr");
        wait_until(t0+T+4);
        err_clr = 1'b0;
        wait_until(t0+T+7);

        // all clusters requested together, staggered acks, then reset in GATED
        t0 = cyc;
        gate_req = '1;
        for (int i = 0; i < N; i++) begin
            m = N'(1) << i;
            expect_at(t0+10+i, S_CLKEN, m, m,  "ind_clken_before");
            expect_at(t0+11+i, S_CLKEN, m, '0, "ind_clken_fall");
            expect_at(t0+11+i, S_GATED, m, m,  "ind_gated");
        end
        expect_at(t0+20, S_CLKEN, '1, '0, "ind_all_gated");
        for (int i = 0; i < N; i++) begin
            wait_until(t0+2+i);
            isolated[i] = 1'b1;
        end
        wait_until(t0+20);
        rst      = 1'b1;
        gate_req = '0;
        expect_idle(t0+21, "rst_gated");
        expect_idle(t0+22, "rst_after");
        wait_until(t0+21);
        rst      = 1'b0;
        isolated = '0;
        wait_until(t0+25);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
